// File: rtl/binary_mul_pkg.sv
// Shared constants for the signed 7x7 Baugh-Wooley multiplier.
//   WA, WB, WP   : operand and product widths (WP = WA + WB - 1)
//   WS           : width of the full internal product
//   BW_CORR      : Baugh-Wooley correction constant (bits 7 and 13 set)
//   P_MAX, P_MIN : 13-bit signed saturation limits
package binary_mul_pkg;

  localparam int unsigned WA = 7;
  localparam int unsigned WB = 7;
  localparam int unsigned WP = WA + WB - 1;
  localparam int unsigned WS = WA + WB;

  // Correction for inverting the mixed sign-bit partial products:
  // 2^(wa-1) + 2^(wb-1) + 2^(wa+wb-1). For 7x7 this is bit 7 plus bit 13.
  function automatic logic [63:0] bw_corr(input int unsigned wa, input int unsigned wb);
    return (64'd1 << (wa - 1)) + (64'd1 << (wb - 1)) + (64'd1 << (wa + wb - 1));
  endfunction

  localparam logic [WS-1:0] BW_CORR = WS'(bw_corr(WA, WB));

  localparam logic signed [WP-1:0] P_MAX = {1'b0, {(WP-1){1'b1}}};
  localparam logic signed [WP-1:0] P_MIN = {1'b1, {(WP-1){1'b0}}};

endpackage

// File: rtl/binary_mul_7_1_bi_fa.sv
// 1-bit full adder used as the cell of the ripple-carry reduction rows.
//   i_a, i_b, i_cin : addend bits and carry in
//   o_sum, o_cout   : sum bit and carry out
module bw_full_adder (
  input  logic i_a,
  input  logic i_b,
  input  logic i_cin,
  output logic o_sum,
  output logic o_cout
);

  assign o_sum  = i_a ^ i_b ^ i_cin;
  assign o_cout = (i_a & i_b) | (i_cin & (i_a ^ i_b));

endmodule

// File: rtl/binary_mul_7_1_bi.sv
// Signed WA x WB two's-complement multiplier (Baugh-Wooley array, ripple
// rows) with a single enabled output register: one cycle latency, a new
// operand pair every cycle.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset, clears P
//   en    : output-register enable; P holds when low
//   A, B  : signed operands
//   P     : registered signed product, low WP bits of A*B
// Build option: BINARY_MUL_SAT_EN saturates the full product to the WP-bit
// signed range instead of wrapping (-64 * -64 -> 4095 rather than -4096).
module binary_mul_7_1_bi #(
  parameter int unsigned WA = binary_mul_pkg::WA,
  parameter int unsigned WB = binary_mul_pkg::WB,
  parameter int unsigned WP = binary_mul_pkg::WP
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic signed [WA-1:0] A,
  input  logic signed [WB-1:0] B,
  output logic signed [WP-1:0] P
);

  import binary_mul_pkg::*;

`ifdef BINARY_MUL_SAT_EN
  localparam int unsigned SW = WA + WB;
`else
  // The top column of the full product only matters for saturation; when
  // wrapping it is dropped, so the array is built WP bits wide.
  localparam int unsigned SW = WP;
`endif

  localparam logic [SW-1:0] CORR = SW'(bw_corr(WA, WB));

  logic [WB-1:0][WA-1:0] w_pp;
  logic [WB-1:0][SW-1:0] w_row;
  logic [WB:0][SW-1:0]   w_acc;
  logic [WB-1:0][SW-1:0] w_cy;
  logic [SW-1:0]         w_sum;
  logic [WP-1:0]         w_next;
  logic [WP-1:0]         r_p;

  // Partial-product rows. Terms pairing exactly one sign bit are inverted;
  // the sign*sign term stays positive.
  for (genvar r = 0; r < WB; r++) begin : g_pp
    localparam logic [WA-1:0] ROW_MASK = (r == WB - 1) ? {1'b0, {(WA-1){1'b1}}}
                                                       : {1'b1, {(WA-1){1'b0}}};
    assign w_pp[r]  = (A & {WA{B[r]}}) ^ ROW_MASK;
    assign w_row[r] = SW'(w_pp[r]) << r;
  end

  // Accumulator seeded with the correction constant, then one ripple adder
  // per row. The MSB carry-out is discarded (modulo 2^SW), so that column
  // is a plain XOR instead of a full adder.
  assign w_acc[0] = CORR;

  for (genvar r = 0; r < WB; r++) begin : g_row
    assign w_cy[r][0] = 1'b0;
    for (genvar k = 0; k < SW - 1; k++) begin : g_bit
      bw_full_adder u_fa (
        .i_a   (w_acc[r][k]),
        .i_b   (w_row[r][k]),
        .i_cin (w_cy[r][k]),
        .o_sum (w_acc[r+1][k]),
        .o_cout(w_cy[r][k+1])
      );
    end
    assign w_acc[r+1][SW-1] = w_acc[r][SW-1] ^ w_row[r][SW-1] ^ w_cy[r][SW-1];
  end

  assign w_sum = w_acc[WB];

  always_comb begin
`ifdef BINARY_MUL_SAT_EN
    w_next = w_sum[WP-1:0];
    // Overflow into the extra column shows up as the top two bits differing.
    if (w_sum[SW-1] != w_sum[SW-2]) begin
      w_next = w_sum[SW-1] ? P_MIN : P_MAX;
    end
`else
    w_next = w_sum;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_p <= '0;
    end else if (en) begin
      r_p <= w_next;
    end
  end

  assign P = r_p;

endmodule

// File: tb/tb_binary_mul_7_1_bi.sv
module tb_binary_mul_7_1_bi;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               en;
  logic signed [6:0]  A;
  logic signed [6:0]  B;
  logic signed [12:0] P;

  int n_checks = 0;
  int n_errors = 0;

  binary_mul_7_1_bi #(.WA(7), .WB(7), .WP(13)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (en),
    .A    (A),
    .B    (B),
    .P    (P)
  );

  always #5 clk = ~clk;

  // Reference: plain integer product, then wrap or saturate to 13 bits.
  function automatic logic signed [12:0] ref_p(input int a, input int b);
    int prod;
    prod = a * b;
`ifdef BINARY_MUL_SAT_EN
    if (prod > 4095)  prod = 4095;
    if (prod < -4096) prod = -4096;
`endif
    return 13'(prod);
  endfunction

  task automatic check(input string name, input logic signed [12:0] act,
                       input logic signed [12:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: P=%0d required %0d", name, act, exp);
    end
  endtask

  // Drive on negedge, sample 1 time unit after the following posedge.
  task automatic apply(input logic signed [6:0] a, input logic signed [6:0] b,
                       input logic e);
    @(negedge clk);
    A  = a;
    B  = b;
    en = e;
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    string              name;
    logic signed [6:0]  a;
    logic signed [6:0]  b;
    logic signed [12:0] p;
  } vec_t;

  vec_t vecs[7];

  initial begin
    logic signed [12:0] exp_p;
    logic               e;
    logic signed [6:0]  ra;
    logic signed [6:0]  rb;

    vecs[0] = '{"neg64x63",  -7'sd64, 7'sd63,  -13'sd4032};
    vecs[1] = '{"63x63",     7'sd63,  7'sd63,  13'sd3969};
    vecs[2] = '{"m1xm1",     -7'sd1,  -7'sd1,  13'sd1};
    vecs[3] = '{"0xneg64",   7'sd0,   -7'sd64, 13'sd0};
    vecs[4] = '{"neg64x1",   -7'sd64, 7'sd1,   -13'sd64};
    vecs[5] = '{"3xneg5",    7'sd3,   -7'sd5,  -13'sd15};
`ifdef BINARY_MUL_SAT_EN
    vecs[6] = '{"overflow",  -7'sd64, -7'sd64, 13'sd4095};
`else
    vecs[6] = '{"overflow",  -7'sd64, -7'sd64, -13'sd4096};
`endif

    // Reset held with live operands.
    rst_n = 1'b0;
    en    = 1'b1;
    A     = 7'sd5;
    B     = 7'sd7;
    @(posedge clk);
    @(posedge clk);
    #1;
    check("reset_hold", P, 13'sd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("reset_release", P, 13'sd35);

    // Corner table.
    foreach (vecs[i]) begin
      apply(vecs[i].a, vecs[i].b, 1'b1);
      check(vecs[i].name, P, vecs[i].p);
    end

    // Enable hold: operands change while en low, P must not move.
    apply(7'sd3, -7'sd5, 1'b1);
    check("hold_load", P, -13'sd15);
    for (int i = 0; i < 3; i++) begin
      apply(7'sd10, 7'sd10, 1'b0);
      check("hold_en0", P, -13'sd15);
    end
    apply(7'sd10, 7'sd10, 1'b1);
    check("hold_reen", P, 13'sd100);

    // Asynchronous reset between edges.
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("async_reset", P, 13'sd0);
    @(posedge clk);
    #1;
    check("async_reset_edge", P, 13'sd0);
    @(negedge clk);
    rst_n = 1'b1;
    A     = 7'sd7;
    B     = -7'sd9;
    en    = 1'b1;
    @(posedge clk);
    #1;
    check("post_reset_first", P, -13'sd63);

    // Exhaustive sweep.
    for (int a = -64; a < 64; a++) begin
      for (int b = -64; b < 64; b++) begin
        apply(7'(a), 7'(b), 1'b1);
        check("sweep", P, ref_p(a, b));
      end
    end

    // Random operands with random enable against the registered model.
    exp_p = P;
    for (int i = 0; i < 2000; i++) begin
      ra = 7'($urandom);
      rb = 7'($urandom);
      e  = ($urandom_range(0, 9) < 7);
      apply(ra, rb, e);
      if (e) exp_p = ref_p(int'(ra), int'(rb));
      check("random", P, exp_p);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/binary_mul_7_1_bi.md
Name: binary_mul_7_1_bi

Overview:
- Signed 7x7 two's-complement multiplier with a single registered output stage.
- The product is computed combinationally from A and B and captured into P on the rising clock edge when enabled. One cycle latency.
- Used as a leaf arithmetic block in datapaths that need a small signed product with a registered output.

Parameters:
- WA, 7, width of operand A (signed).
- WB, 7, width of operand B (signed).
- WP, 13, width of product P (signed); WP = WA + WB - 1.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- en  input  1  output-register enable.
- A  input  7  signed multiplicand.
- B  input  7  signed multiplier.
- P  output  13  signed registered product.

Behaviour:
- Reset: rst_n low asynchronously forces P = 0, independent of clk. Release takes effect at the next rising edge.
- Arithmetic:
  - Full product A*B is formed at 14 bits internally.
  - P takes the low 13 bits (two's-complement wrap).
  - All products are exact except -64 * -64 = +4096, which wraps to P = -4096 (13'h1000).
- Timing:
  - On rising clk with en = 1, P <= low13(A*B).
  - With en = 0, P holds its value.
  - Latency is 1 cycle: operands applied before edge N appear on P after edge N.
  - A new operand pair is accepted every cycle; no handshake, no busy state.
- Structure:
  - Combinational Baugh-Wooley signed array: 7 partial-product rows.
  - Sign-bit partial products are inverted, with correction constants added at bit 7 and bit 13.
  - Rows are summed by a ripple-carry adder chain.
  - The behavioural '*' operator is not used.
- Boundary values:
  - 0 * x = 0.
  - -64 * 63 = -4032.
  - 63 * 63 = 3969.
  - -64 * 1 = -64.
  - -1 * -1 = 1.
- Reset asserted mid-stream clears P immediately. The first valid product appears at the first enabled edge after release.
- Changing A or B while en = 0 has no effect on P.

Optional Feature:
- Macro BINARY_MUL_SAT_EN.
- Defined:
  - The 14-bit product is saturated to the 13-bit signed range [-4096, 4095] before registering.
  - -64 * -64 yields P = 4095.
  - Other results are unchanged.
- Undefined (default): wrap behaviour as above, so -64 * -64 yields P = -4096.

Decomposition:
- Shared package binary_mul_pkg holds:
  - constants WA = 7, WB = 7, WP = 13;
  - Baugh-Wooley correction constant BW_CORR (1 at bit 7 and bit 13 of the 14-bit sum);
  - saturation limits P_MAX = 4095, P_MIN = -4096.
- One sub-module, bw_full_adder (1-bit full adder), is instantiated across the array reduction rows.
- Partial-product generation and the output register stay in the top module.

Test Plan:
- Reset: rst_n = 0 with A = 5, B = 7 and en = 1 -> P = 0 while reset is held. After release and one edge, P = 35.
- Exhaustive sweep: A, B each over -64..63 with en = 1. Apply on negedge, check after the following posedge -> P == low13(A*B) for all 16384 pairs.
- Corners:
  - A = -64, B = 63 -> P = -4032.
  - A = 63, B = 63 -> P = 3969.
  - A = -1, B = -1 -> P = 1.
  - A = 0, B = -64 -> P = 0.
- Overflow: A = -64, B = -64 -> P = -4096 without BINARY_MUL_SAT_EN, and P = 4095 with it defined.
- Enable hold: load A = 3, B = -5 (P = -15), then set en = 0 and A = 10, B = 10 for 3 cycles -> P stays -15. Raise en -> P = 100 after the next edge.
- Async reset mid-stream: with P = 100, pulse rst_n low between edges -> P drops to 0 before the next clk edge.
